// File: rtl/nina_pkg.sv
// Shared helpers for the NINA masked XOR pipeline: vector sizing, share/copy bit
// indexing and the legal parameter ranges.
package nina_pkg;

  localparam int MAX_STAGES = 4;

  function automatic int nina_width(input int shares, input int copies, input int width);
    return shares * copies * width;
  endfunction

  // Flat position of bit w of copy c of share s.
  function automatic int bit_idx(input int s, input int c, input int w,
                                 input int copies, input int width);
    return ((s * copies) + c) * width + w;
  endfunction

  function automatic bit nina_params_ok(input int shares, input int copies,
                                        input int width, input int stages);
    return (shares >= 2) && (copies >= 1) && (width >= 1) &&
           (stages >= 1) && (stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/masked_pipe_stage.sv
// One elastic valid/ready register slice; holds whole share vectors only.
module masked_pipe_stage #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;
  logic         load;

  // Load when empty or when downstream takes the current entry; the data register
  // only moves on a real transfer so an empty slice keeps its old contents.
  always_comb begin
    load     = ~valid_q | out_ready;
    in_ready = load;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/masked_xor_nina_pipe.sv
// Share-wise, copy-wise masked XOR feeding an elastic register pipeline, with a
// share-local copy comparator raising a sticky fault flag at the output.
module masked_xor_nina_pipe
  import nina_pkg::*;
#(
  parameter int SHARES  = 2,
  parameter int COPIES  = 3,
  parameter int WIDTH   = 1,
  parameter int STAGES  = 1,
  parameter int ZEROIZE = 1,
  localparam int N = nina_width(SHARES, COPIES, WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] port_a,
  input  logic [N-1:0] port_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] port_c,
  input  logic         fault_clr,
  output logic         fault_o
);

  if (!nina_params_ok(SHARES, COPIES, WIDTH, STAGES)) begin : g_bad_params
    $error("masked_xor_nina_pipe: SHARES/COPIES/WIDTH/STAGES out of range");
  end

  // A bitwise XOR of the flat vectors never mixes two shares: bit i of A only meets bit i of B.
  logic [N-1:0] xor_data;
  assign xor_data = port_a ^ port_b;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic         up_valid;
    logic [N-1:0] up_data;
    logic         dn_ready;
    logic         stage_ready;
    logic         stage_valid;
    logic [N-1:0] stage_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = xor_data;
    end else begin : g_link
      assign up_valid = g_stage[i-1].stage_valid;
      assign up_data  = g_stage[i-1].stage_data;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_stage[i+1].stage_ready;
    end

    masked_pipe_stage #(.N(N)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid),
      .in_ready  (stage_ready),
      .in_data   (up_data),
      .out_valid (stage_valid),
      .out_ready (dn_ready),
      .out_data  (stage_data)
    );
  end

  logic         last_valid;
  logic [N-1:0] last_data;
  assign in_ready   = g_stage[0].stage_ready;
  assign last_valid = g_stage[STAGES-1].stage_valid;
  assign last_data  = g_stage[STAGES-1].stage_data;

  // Each copy is compared against copy 0 of the same share and bit; copy-0 slots never flag.
  logic [N-1:0] copy_neq;
  for (genvar s = 0; s < SHARES; s++) begin : g_cmp_s
    for (genvar c = 0; c < COPIES; c++) begin : g_cmp_c
      for (genvar w = 0; w < WIDTH; w++) begin : g_cmp_w
        if (c == 0) begin : g_ref
          assign copy_neq[bit_idx(s, c, w, COPIES, WIDTH)] = 1'b0;
        end else begin : g_chk
          assign copy_neq[bit_idx(s, c, w, COPIES, WIDTH)] =
            last_data[bit_idx(s, c, w, COPIES, WIDTH)] ^
            last_data[bit_idx(s, 0, w, COPIES, WIDTH)];
        end
      end
    end
  end

  logic mismatch;
  assign mismatch = last_valid & (|copy_neq);

  logic fault_q, fault_d;

  // Sticky flag; a fresh mismatch outranks a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (fault_clr) begin
      fault_d = 1'b0;
    end
    if (mismatch) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_o   = fault_q;
  assign out_valid = last_valid;
  assign port_c    = ((ZEROIZE != 0) && fault_q) ? '0 : last_data;

endmodule

// File: tb/tb_masked_xor_nina_pipe.sv
// Randomised bench for masked_xor_nina_pipe against a FIFO-style reference model of
// the elastic pipeline, fault flag and zeroisation.
module tb_masked_xor_nina_pipe;

  localparam int SH = 3;
  localparam int CP = 3;
  localparam int WD = 2;
  localparam int ST = 3;
  localparam int N  = SH * CP * WD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         fault_clr = 1'b0;
  logic [N-1:0] port_a = '0;
  logic [N-1:0] port_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         fault_o;
  logic [N-1:0] port_c;

  masked_xor_nina_pipe #(
    .SHARES(SH), .COPIES(CP), .WIDTH(WD), .STAGES(ST), .ZEROIZE(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .port_a    (port_a),
    .port_b    (port_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .port_c    (port_c),
    .fault_clr (fault_clr),
    .fault_o   (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  data;
    logic [WD-1:0] plain;
    int            elig;
  } entry_t;

  entry_t q[$];
  int     step = 0;
  int     compared = 0;
  int     mismatched = 0;
  bit     model_fault = 1'b0;
  bit     accepted = 1'b0;

  function automatic int idx(input int s, input int c, input int w);
    return ((s * CP) + c) * WD + w;
  endfunction

  // Random sharing of v: SH-1 random shares plus a closing share, replicated to every copy.
  function automatic logic [N-1:0] make_masked(input logic [WD-1:0] v);
    logic [WD-1:0] sh [SH];
    logic [WD-1:0] acc;
    logic [N-1:0]  r;
    acc = v;
    for (int s = 0; s < SH - 1; s++) begin
      sh[s] = WD'($urandom);
      acc   = acc ^ sh[s];
    end
    sh[SH-1] = acc;
    r = '0;
    for (int s = 0; s < SH; s++)
      for (int c = 0; c < CP; c++)
        for (int w = 0; w < WD; w++)
          r[idx(s, c, w)] = sh[s][w];
    return r;
  endfunction

  function automatic logic [WD-1:0] unmask(input logic [N-1:0] vec, input int c);
    logic [WD-1:0] acc;
    acc = '0;
    for (int s = 0; s < SH; s++)
      for (int w = 0; w < WD; w++)
        acc[w] = acc[w] ^ vec[idx(s, c, w)];
    return acc;
  endfunction

  function automatic bit consistent(input logic [N-1:0] vec);
    for (int s = 0; s < SH; s++)
      for (int c = 1; c < CP; c++)
        for (int w = 0; w < WD; w++)
          if (vec[idx(s, c, w)] !== vec[idx(s, 0, w)]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  // Samples the DUT mid-cycle, compares with the model, then advances the model by one edge.
  task automatic checkOutput();
    bit           exp_in_ready;
    bit           exp_ov;
    bit           mism;
    logic [N-1:0] exp_c;
    entry_t       e;
    #1;
    exp_in_ready = (q.size() < ST) || out_ready;
    exp_ov       = (q.size() > 0) && (q[0].elig <= step);
    check("in_ready", N'(in_ready), N'(exp_in_ready));
    check("out_valid", N'(out_valid), N'(exp_ov));
    check("fault_o", N'(fault_o), N'(model_fault));
    mism = 1'b0;
    if (exp_ov) begin
      exp_c = model_fault ? '0 : q[0].data;
      check("port_c", port_c, exp_c);
      mism = !consistent(q[0].data);
      if (!model_fault && !mism)
        for (int c = 0; c < CP; c++)
          check("unmasked", N'(unmask(port_c, c)), N'(q[0].plain));
    end
    accepted = in_valid && exp_in_ready;
    if (exp_ov && out_ready) begin
      void'(q.pop_front());
      if (q.size() > 0 && q[0].elig < step + 1) q[0].elig = step + 1;
    end
    if (accepted) begin
      e.data  = port_a ^ port_b;
      e.plain = 'x;
      e.elig  = step + ST;
      q.push_back(e);
    end
    model_fault = (model_fault && !fault_clr) || mism;
    @(posedge clk);
    @(negedge clk);
    step++;
  endtask

  task automatic applyStimulus(input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [WD-1:0] plain, input bit ordy, input bit clr);
    in_valid  = v;
    port_a    = a;
    port_b    = b;
    out_ready = ordy;
    fault_clr = clr;
    checkOutput();
    if (accepted) q[q.size()-1].plain = plain;
  endtask

  logic [N-1:0]  a, b;
  logic [WD-1:0] va, vb;
  bit            pend;

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_port_c", port_c, '0);
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_fault", N'(fault_o), N'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed pair: A = share0 all ones, B = share1 all ones, unmasked 1 ^ 1 = 0
    a = '0;
    b = '0;
    for (int c = 0; c < CP; c++)
      for (int w = 0; w < WD; w++) begin
        a[idx(0, c, w)] = 1'b1;
        b[idx(1, c, w)] = 1'b1;
      end
    applyStimulus(1'b1, a, b, '0, 1'b1, 1'b0);
    for (int i = 0; i < ST + 1; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Back-to-back stream of 8 random consistent pairs
    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      va = WD'($urandom);
      vb = WD'($urandom);
      applyStimulus(1'b1, make_masked(va), make_masked(vb), va ^ vb, 1'b1, 1'b0);
    end
    for (int i = 0; i < ST + 1; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Consumer stalls for 5 cycles mid-stream; operands held until accepted
    $display("[TB] stall");
    pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!pend) begin
        va = WD'($urandom);
        vb = WD'($urandom);
        a  = make_masked(va);
        b  = make_masked(vb);
        pend = 1'b1;
      end
      applyStimulus(1'b1, a, b, va ^ vb, !(i >= 4 && i < 9), 1'b0);
      if (accepted) pend = 1'b0;
    end
    for (int i = 0; i < ST + 1; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Copy 1 of share 0 corrupted, then cleared; then a clear coinciding with a new mismatch
    $display("[TB] fault");
    va = WD'($urandom);
    vb = WD'($urandom);
    a  = make_masked(va);
    a[idx(0, 1, 0)] = ~a[idx(0, 1, 0)];
    applyStimulus(1'b1, a, make_masked(vb), va ^ vb, 1'b1, 1'b0);
    for (int i = 0; i < ST + 2; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
    va = WD'($urandom);
    vb = WD'($urandom);
    applyStimulus(1'b1, make_masked(va), make_masked(vb), va ^ vb, 1'b1, 1'b0);
    for (int i = 0; i < ST + 1; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, a, make_masked(vb), va ^ vb, 1'b1, 1'b1);
    for (int i = 0; i < ST + 2; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries in flight
    $display("[TB] reset in flight");
    for (int i = 0; i < 2; i++) begin
      va = WD'($urandom);
      vb = WD'($urandom);
      applyStimulus(1'b1, make_masked(va), make_masked(vb), va ^ vb, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", N'(out_valid), N'(0));
    check("midrst_port_c", port_c, '0);
    check("midrst_in_ready", N'(in_ready), N'(1));
    q.delete();
    model_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step++;
    for (int i = 0; i < ST + 2; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Random valid/ready traffic
    $display("[TB] random traffic");
    pend = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!pend) begin
        va = WD'($urandom);
        vb = WD'($urandom);
        a  = make_masked(va);
        b  = make_masked(vb);
      end
      pend = pend | ($urandom_range(0, 3) != 0);
      applyStimulus(pend, a, b, va ^ vb, $urandom_range(0, 9) < 7, 1'b0);
      if (accepted) pend = 1'b0;
    end
    for (int i = 0; i < ST + 6; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
